// File: rtl/p_hardisc.sv
// Shared definitions for the machine timer: register offsets, CTRL field
// positions and the AHB response state encoding.
package p_hardisc;

    localparam logic [4:0] ADDR_MTIME_LO      = 5'h00;
    localparam logic [4:0] ADDR_MTIME_HI      = 5'h04;
    localparam logic [4:0] ADDR_MTIMECMP_LO   = 5'h08;
    localparam logic [4:0] ADDR_MTIMECMP_HI   = 5'h0C;
    localparam logic [4:0] ADDR_CTRL          = 5'h10;
    localparam logic [4:0] ADDR_MTIME_HI_SNAP = 5'h14;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_DIV_LSB = 8;

    typedef enum logic [1:0] {
        RESP_OKAY = 2'd0,
        RESP_ERR1 = 2'd1,
        RESP_ERR2 = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mtimer_counter.sv
// Prescaler and 64-bit mtime counter. A bus write to either half overrides
// the tick increment in the same cycle.
module mtimer_counter #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic [PRESC_W-1:0] i_div,
    input  logic               i_presc_clr,
    input  logic               i_wr_lo,
    input  logic               i_wr_hi,
    input  logic [31:0]        i_wdata,
    output logic [63:0]        o_mtime
);

    logic [PRESC_W-1:0] r_presc;
    logic [63:0]        r_mtime;
    logic               w_tick;

    assign w_tick  = i_en && (r_presc == i_div);
    assign o_mtime = r_mtime;

    // Prescaler: counts while enabled, wraps to 0 on a tick or CTRL write.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_en || i_presc_clr || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // mtime: bus write wins over the tick increment.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mtime <= '0;
        end else if (i_wr_lo) begin
            r_mtime[31:0] <= i_wdata;
        end else if (i_wr_hi) begin
            r_mtime[63:32] <= i_wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

endmodule

// File: rtl/hardisc_mtimer.sv
// RISC-V machine timer with an AHB-Lite slave register window.
module hardisc_mtimer
    import p_hardisc::*;
#(
    parameter int unsigned PRESC_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic        s_hwrite_i,
    input  logic [2:0]  s_hsize_i,
    input  logic        s_hready_i,
    input  logic [31:0] s_hwdata_i,
    output logic [31:0] s_hrdata_o,
    output logic        s_hreadyout_o,
    output logic        s_hresp_o,
    output logic        s_int_mtip_o
);

    resp_state_e r_state, w_state_next;

    logic [4:0]         w_off;
    logic               w_accept, w_valid, w_bad;
    logic               r_dp_wr, r_dp_rd;
    logic [4:0]         r_dp_off;
    logic [63:0]        r_mtimecmp;
    logic               r_en;
    logic [PRESC_W-1:0] r_div;
    logic [31:0]        r_snap;
    logic               r_mtip;
    logic [63:0]        w_mtime;
    logic [31:0]        w_ctrl;
    logic               w_wr_lo, w_wr_hi, w_wr_cmplo, w_wr_cmphi, w_wr_ctrl, w_rd_lo;
    logic               w_unused;

    // Only the low five address bits select a register.
    assign w_unused = ^{s_haddr_i[31:5], s_htrans_i[0], BASE_ADDR};

    assign w_off    = s_haddr_i[4:0];
    assign w_accept = s_hsel_i && s_hready_i && s_htrans_i[1];
    assign w_valid  = (s_hsize_i == 3'b010) && (w_off[1:0] == 2'b00) &&
                      (w_off <= ADDR_MTIME_HI_SNAP) &&
                      !(s_hwrite_i && (w_off == ADDR_MTIME_HI_SNAP));
    assign w_bad    = w_accept && !w_valid;

    // Address phase register; invalid transfers never reach the data phase.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_dp_wr  <= 1'b0;
            r_dp_rd  <= 1'b0;
            r_dp_off <= '0;
        end else if (s_hready_i) begin
            r_dp_wr  <= w_accept && w_valid && s_hwrite_i;
            r_dp_rd  <= w_accept && w_valid && !s_hwrite_i;
            r_dp_off <= w_off;
        end
    end

    assign w_wr_lo    = r_dp_wr && (r_dp_off == ADDR_MTIME_LO);
    assign w_wr_hi    = r_dp_wr && (r_dp_off == ADDR_MTIME_HI);
    assign w_wr_cmplo = r_dp_wr && (r_dp_off == ADDR_MTIMECMP_LO);
    assign w_wr_cmphi = r_dp_wr && (r_dp_off == ADDR_MTIMECMP_HI);
    assign w_wr_ctrl  = r_dp_wr && (r_dp_off == ADDR_CTRL);
    assign w_rd_lo    = r_dp_rd && (r_dp_off == ADDR_MTIME_LO);

    mtimer_counter #(
        .PRESC_W (PRESC_W)
    ) u_counter (
        .i_clk       (s_clk_i),
        .i_reset     (s_reset_i),
        .i_en        (r_en),
        .i_div       (r_div),
        .i_presc_clr (w_wr_ctrl),
        .i_wr_lo     (w_wr_lo),
        .i_wr_hi     (w_wr_hi),
        .i_wdata     (s_hwdata_i),
        .o_mtime     (w_mtime)
    );

    // Compare register halves.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_mtimecmp <= '1;
        end else if (w_wr_cmplo) begin
            r_mtimecmp[31:0] <= s_hwdata_i;
        end else if (w_wr_cmphi) begin
            r_mtimecmp[63:32] <= s_hwdata_i;
        end
    end

    // CTRL register: enable and prescaler divider.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_en  <= 1'b0;
            r_div <= '0;
        end else if (w_wr_ctrl) begin
            r_en  <= s_hwdata_i[CTRL_EN_BIT];
            r_div <= s_hwdata_i[CTRL_DIV_LSB +: PRESC_W];
        end
    end

    // Snapshot HI on every MTIME_LO read for a coherent 64-bit read pair.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_snap <= '0;
        end else if (w_rd_lo) begin
            r_snap <= w_mtime[63:32];
        end
    end

    // Registered interrupt compare.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_mtip <= 1'b0;
        end else begin
            r_mtip <= r_en && (w_mtime >= r_mtimecmp);
        end
    end

    assign s_int_mtip_o = r_mtip;

    // Read data mux, zero outside a valid read data phase.
    always_comb begin
        w_ctrl = '0;
        w_ctrl[CTRL_EN_BIT] = r_en;
        w_ctrl[CTRL_DIV_LSB +: PRESC_W] = r_div;
        s_hrdata_o = '0;
        if (r_dp_rd) begin
            case (r_dp_off)
                ADDR_MTIME_LO:      s_hrdata_o = w_mtime[31:0];
                ADDR_MTIME_HI:      s_hrdata_o = w_mtime[63:32];
                ADDR_MTIMECMP_LO:   s_hrdata_o = r_mtimecmp[31:0];
                ADDR_MTIMECMP_HI:   s_hrdata_o = r_mtimecmp[63:32];
                ADDR_CTRL:          s_hrdata_o = w_ctrl;
                ADDR_MTIME_HI_SNAP: s_hrdata_o = r_snap;
                default:            s_hrdata_o = '0;
            endcase
        end
    end

    // Response FSM state register.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_state <= RESP_OKAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Response FSM next state and AHB response outputs.
    always_comb begin
        w_state_next  = r_state;
        s_hreadyout_o = 1'b1;
        s_hresp_o     = 1'b0;
        case (r_state)
            RESP_OKAY: begin
                if (w_bad) w_state_next = RESP_ERR1;
            end
            RESP_ERR1: begin
                s_hreadyout_o = 1'b0;
                s_hresp_o     = 1'b1;
                w_state_next  = RESP_ERR2;
            end
            RESP_ERR2: begin
                s_hresp_o    = 1'b1;
                w_state_next = w_bad ? RESP_ERR1 : RESP_OKAY;
            end
            default: w_state_next = RESP_OKAY;
        endcase
    end

endmodule

// File: tb/tb_hardisc_mtimer.sv
// Directed self-checking bench for hardisc_mtimer.
module tb_hardisc_mtimer;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        mtip;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Single-slave bus: HREADY is this slave's HREADYOUT.
    assign hready = hreadyout;

    hardisc_mtimer #(
        .PRESC_W   (8),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .s_clk_i       (clk),
        .s_reset_i     (rst),
        .s_hsel_i      (hsel),
        .s_haddr_i     (haddr),
        .s_htrans_i    (htrans),
        .s_hwrite_i    (hwrite),
        .s_hsize_i     (hsize),
        .s_hready_i    (hready),
        .s_hwdata_i    (hwdata),
        .s_hrdata_o    (hrdata),
        .s_hreadyout_o (hreadyout),
        .s_hresp_o     (hresp),
        .s_int_mtip_o  (mtip)
    );

    task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = {27'h0, off}; hwrite = 1'b1; hsize = 3'b010;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
        @(posedge clk);
    endtask

    task automatic bus_read(input logic [4:0] off, output logic [31:0] data);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = {27'h0, off}; hwrite = 1'b0; hsize = 3'b010;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        data = hrdata;
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [4:0]  offs [6] = '{5'h14, 5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
        logic [31:0] exps [6] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0 || mtip !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b_%h_%b exp=10_00000000_0", hreadyout, hresp, hrdata, mtip);
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(offs[i], d);
            checks++;
            if (d !== exps[i]) begin
                failures++;
                $display("FAIL reset_reg[%0d] got=%h exp=%h", i, d, exps[i]);
            end
        end
    endtask

    task automatic test_ctrl_fields();
        logic [31:0] d;
        bus_write(5'h10, 32'hFFFF_FFFF);
        bus_read(5'h10, d);
        checks++;
        if (d !== 32'h0000_FF01) begin
            failures++;
            $display("FAIL ctrl_all_ones got=%h exp=%h", d, 32'h0000_FF01);
        end
        bus_write(5'h10, 32'hABCD_5A00);
        bus_read(5'h10, d);
        checks++;
        if (d !== 32'h0000_5A00) begin
            failures++;
            $display("FAIL ctrl_div_only got=%h exp=%h", d, 32'h0000_5A00);
        end
    endtask

    task automatic test_count();
        logic [31:0] d;
        logic [31:0] exps [3] = '{32'd1, 32'd3, 32'd5};
        bus_write(5'h10, 32'h0000_0001);
        // Each read samples two cycles after the previous one.
        for (int i = 0; i < 3; i++) begin
            bus_read(5'h00, d);
            checks++;
            if (d !== exps[i]) begin
                failures++;
                $display("FAIL count_lo[%0d] got=%h exp=%h", i, d, exps[i]);
            end
        end
        checks++;
        if (mtip !== 1'b0) begin
            failures++;
            $display("FAIL count_mtip got=%b exp=0", mtip);
        end
    endtask

    task automatic test_carry();
        logic [31:0] d;
        logic [31:0] exps [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        bus_write(5'h10, 32'h0);
        bus_write(5'h00, 32'hFFFF_FFFE);
        bus_write(5'h04, 32'h0);
        bus_write(5'h10, 32'h0000_0301);
        for (int i = 0; i < 5; i++) begin
            bus_read(5'h00, d);
            checks++;
            if (d !== exps[i]) begin
                failures++;
                $display("FAIL carry_lo[%0d] got=%h exp=%h", i, d, exps[i]);
            end
        end
        bus_read(5'h04, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL carry_hi got=%h exp=%h", d, 32'h1);
        end
    endtask

    task automatic test_mtip();
        logic [31:0] d;
        logic exp_irq;
        bus_write(5'h10, 32'h0);
        bus_write(5'h08, 32'd10);
        bus_write(5'h0C, 32'h0);
        bus_write(5'h00, 32'h0);
        bus_write(5'h04, 32'h0);
        bus_write(5'h10, 32'h0000_0001);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            exp_irq = (k >= 11);
            checks++;
            if (mtip !== exp_irq) begin
                failures++;
                $display("FAIL mtip_rise[%0d] got=%b exp=%b", k, mtip, exp_irq);
            end
        end
        bus_write(5'h0C, 32'hFFFF_FFFF);
        @(negedge clk);
        checks++;
        if (mtip !== 1'b1) begin
            failures++;
            $display("FAIL mtip_hold got=%b exp=1", mtip);
        end
        @(negedge clk);
        checks++;
        if (mtip !== 1'b0) begin
            failures++;
            $display("FAIL mtip_clear got=%b exp=0", mtip);
        end
        bus_write(5'h08, 32'hFFFF_FFFF);
        bus_read(5'h08, d);
        checks++;
        if (d !== 32'hFFFF_FFFF || mtip !== 1'b0) begin
            failures++;
            $display("FAIL mtip_cmp_max got=%h/%b exp=ffffffff/0", d, mtip);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [4:0]  e_off [3] = '{5'h00, 5'h18, 5'h14};
        logic        e_wr  [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0]  e_sz  [3] = '{3'b000, 3'b010, 3'b010};
        bus_write(5'h10, 32'h0);
        bus_write(5'h00, 32'h1234_5678);
        bus_write(5'h04, 32'hCAFE_0001);
        bus_read(5'h00, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            failures++;
            $display("FAIL err_pre_lo got=%h exp=%h", d, 32'h1234_5678);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hsel = 1'b1; htrans = 2'b10; haddr = {27'h0, e_off[i]}; hwrite = e_wr[i]; hsize = e_sz[i];
            @(negedge clk);
            hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
            checks++;
            if (hreadyout !== 1'b0 || hresp !== 1'b1 || hrdata !== 32'h0) begin
                failures++;
                $display("FAIL err1[%0d] got=%b%b_%h exp=01_00000000", i, hreadyout, hresp, hrdata);
            end
            @(negedge clk);
            checks++;
            if (hreadyout !== 1'b1 || hresp !== 1'b1) begin
                failures++;
                $display("FAIL err2[%0d] got=%b%b exp=11", i, hreadyout, hresp);
            end
            @(negedge clk);
            checks++;
            if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
                failures++;
                $display("FAIL err_okay[%0d] got=%b%b exp=10", i, hreadyout, hresp);
            end
        end
        bus_read(5'h00, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            failures++;
            $display("FAIL err_post_lo got=%h exp=%h", d, 32'h1234_5678);
        end
        bus_read(5'h14, d);
        checks++;
        if (d !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL err_post_snap got=%h exp=%h", d, 32'hCAFE_0001);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_001C; hwrite = 1'b0; hsize = 3'b010;
        @(negedge clk);
        haddr = 32'h0000_0002;
        checks++;
        if (hreadyout !== 1'b0 || hresp !== 1'b1) begin
            failures++;
            $display("FAIL b2b_err1a got=%b%b exp=01", hreadyout, hresp);
        end
        @(negedge clk);
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b1) begin
            failures++;
            $display("FAIL b2b_err2a got=%b%b exp=11", hreadyout, hresp);
        end
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        checks++;
        if (hreadyout !== 1'b0 || hresp !== 1'b1) begin
            failures++;
            $display("FAIL b2b_err1b got=%b%b exp=01", hreadyout, hresp);
        end
        @(negedge clk);
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b1) begin
            failures++;
            $display("FAIL b2b_err2b got=%b%b exp=11", hreadyout, hresp);
        end
        @(negedge clk);
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
            failures++;
            $display("FAIL b2b_okay got=%b%b exp=10", hreadyout, hresp);
        end
    endtask

    task automatic test_write_tick();
        logic [31:0] d;
        bus_write(5'h10, 32'h0000_0001);
        bus_write(5'h04, 32'h7);
        bus_write(5'h00, 32'h0000_0100);
        bus_read(5'h00, d);
        checks++;
        if (d !== 32'h0000_0101) begin
            failures++;
            $display("FAIL wr_tick_lo got=%h exp=%h", d, 32'h0000_0101);
        end
        bus_write(5'h00, 32'hFFFF_FFFD);
        bus_read(5'h00, d);
        checks++;
        if (d !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL snap_lo got=%h exp=%h", d, 32'hFFFF_FFFE);
        end
        bus_read(5'h14, d);
        checks++;
        if (d !== 32'h7) begin
            failures++;
            $display("FAIL snap_value got=%h exp=%h", d, 32'h7);
        end
        bus_read(5'h04, d);
        checks++;
        if (d !== 32'h8) begin
            failures++;
            $display("FAIL snap_hi_now got=%h exp=%h", d, 32'h8);
        end
    endtask

    task automatic test_reset_err1();
        logic [31:0] d;
        logic [4:0]  offs [6] = '{5'h14, 5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
        logic [31:0] exps [6] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        bus_write(5'h08, 32'h5);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_001C; hwrite = 1'b0; hsize = 3'b010;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        checks++;
        if (hreadyout !== 1'b0 || hresp !== 1'b1) begin
            failures++;
            $display("FAIL rst_err1_entry got=%b%b exp=01", hreadyout, hresp);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || mtip !== 1'b0 || hrdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_err1_abort got=%b%b_%b_%h exp=10_0_00000000", hreadyout, hresp, mtip, hrdata);
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(offs[i], d);
            checks++;
            if (d !== exps[i]) begin
                failures++;
                $display("FAIL rst_err1_reg[%0d] got=%h exp=%h", i, d, exps[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; hwdata = '0;
        test_reset();
        test_ctrl_fields();
        test_count();
        test_carry();
        test_mtip();
        test_errors();
        test_back_to_back();
        test_write_tick();
        test_reset_err1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hardisc_mtimer.md
HARDISC_MTIMER -- requirements
Module: hardisc_mtimer

Interface
REQ-001 Parameter PRESC_W, default 8: width of prescaler divider field and counter.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: base of the 32-byte register window; only haddr[4:0] is decoded.
REQ-003 s_clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 s_reset_i  input  1  reset, synchronous and active-high.
REQ-005 s_hsel_i  input  1  AHB-Lite slave select.
REQ-006 s_haddr_i  input  32  AHB address, address phase.
REQ-007 s_htrans_i  input  2  AHB transfer type; NONSEQ/SEQ are active.
REQ-008 s_hwrite_i  input  1  AHB write indicator.
REQ-009 s_hsize_i  input  3  AHB transfer size.
REQ-010 s_hready_i  input  1  bus-level HREADY; the address phase is sampled only when it is 1.
REQ-011 s_hwdata_i  input  32  AHB write data, data phase.
REQ-012 s_hrdata_o  output  32  AHB read data, data phase.
REQ-013 s_hreadyout_o  output  1  slave ready.
REQ-014 s_hresp_o  output  1  slave error response.
REQ-015 s_int_mtip_o  output  1  machine timer interrupt; drives the core's s_int_mtip_i.

Function
REQ-016 Register map (word offsets):
- 0x00 MTIME_LO, RW.
- 0x04 MTIME_HI, RW.
- 0x08 MTIMECMP_LO, RW.
- 0x0C MTIMECMP_HI, RW.
- 0x10 CTRL, RW: bit0 EN, bits[8+PRESC_W-1:8] DIV, other bits read 0.
- 0x14 MTIME_HI_SNAP, RO.
- 0x18 and 0x1C are invalid.
REQ-017 Accepted transfer: s_hsel_i & s_hready_i & s_htrans_i[1]; address, write and size are registered at the end of the address phase.
REQ-018 A valid transfer has s_hsize_i=3'b010, haddr[1:0]=0, offset<=0x14, and is not a write to 0x14; valid transfers complete with zero wait states: s_hreadyout_o=1, s_hresp_o=0.
REQ-019 An invalid transfer produces the two-cycle AHB ERROR response and has no register side effect.
REQ-020 Response FSM:
- OKAY -> ERR1 on an accepted invalid transfer.
- ERR1 (hreadyout=0, hresp=1) -> ERR2 unconditionally.
- ERR2 (hreadyout=1, hresp=1) -> OKAY, or -> ERR1 if the next accepted transfer is also invalid.
REQ-021 Writes update the target register at the clock edge that ends the data phase, using s_hwdata_i.
REQ-022 s_hrdata_o is combinational from the registered offset during the data phase; it is 0 outside a valid read data phase.
REQ-023 A read of MTIME_LO captures MTIME_HI into the snapshot register in the same cycle, so software can read a coherent 64-bit value.
REQ-024 Prescaler: when EN=1 the counter increments each cycle; when counter==DIV, a tick is generated and the counter returns to 0. With DIV=0, mtime increments every cycle.
REQ-025 Each tick increments the 64-bit mtime by 1, with carry from LO into HI; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-026 A bus write to MTIME_LO or MTIME_HI in the same cycle as a tick takes priority; the written half takes the write data, the other half keeps its value, and no increment occurs.
REQ-027 EN=0 freezes mtime and holds the prescaler counter at 0; a write to CTRL also clears the prescaler counter.
REQ-028 s_int_mtip_o is registered: it equals EN & (mtime >= mtimecmp), unsigned 64-bit compare, evaluated one cycle earlier.

Reset
REQ-029 On s_reset_i=1 at a clock edge the block takes these values:
- mtime=0, snapshot=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
- EN=0, DIV=0, prescaler counter=0.
- FSM=OKAY, registered address phase cleared.
- s_hreadyout_o=1, s_hresp_o=0, s_hrdata_o=0, s_int_mtip_o=0.
REQ-030 Reset asserted during an ERR1 or ERR2 response aborts the response; the next cycle is OKAY.

Structure
REQ-031 The register offset localparams, the CTRL field positions and the response FSM state enum belong in p_hardisc.
REQ-032 The prescaler and 64-bit counter are a natural sub-module, mtimer_counter (tick, write-override, carry); bus decode and the FSM stay in the top.

Verification
REQ-033 Reset, then write CTRL=32'h0000_0001 (EN=1, DIV=0) -> mtime reads 1 after the first counting cycle and increments by 1 every cycle; s_int_mtip_o stays 0.
REQ-034 Write MTIME_LO=32'hFFFF_FFFE, MTIME_HI=0, then CTRL=32'h0000_0301 (EN=1, DIV=3) -> a tick every 4 cycles; after 2 ticks MTIME_LO=0 and MTIME_HI=1 (carry).
REQ-035 Write MTIMECMP={32'h0,32'd10}, mtime=0, EN=1, DIV=0 -> s_int_mtip_o rises one cycle after mtime reaches 10; writing MTIMECMP_LO=32'hFFFF_FFFF with MTIMECMP_HI=32'hFFFF_FFFF clears it one cycle later.
REQ-036 Byte write (hsize=0) to 0x00, read of 0x18, and write to 0x14 -> each returns hreadyout=0/hresp=1 then hreadyout=1/hresp=1; register contents are unchanged.
REQ-037 Bus write to MTIME_LO in a tick cycle -> the written value is held with no +1; read MTIME_LO then MTIME_HI_SNAP while HI changes between the reads -> the snapshot equals HI at the time of the LO read.
REQ-038 Assert s_reset_i during ERR1 -> the next cycle shows hreadyout=1, hresp=0, and all registers hold their reset values.
